// File: rtl/shift_8x64_feeder.sv
// Feeder for a WIDTH x DEPTH shift register: registers accepted bytes into shift/sr_in and flushes with zeros.
// Optional stall counter enabled by defining SR_FEED_STALL_CNT_EN.
module shift_8x64_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             shift,
    output logic [WIDTH-1:0] sr_in,
    output logic [6:0]       fill_level,
    output logic             primed,
    output logic             busy
`ifdef SR_FEED_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam logic [6:0] DEPTH_L = 7'(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [6:0]       fill_q, fill_d;
    logic [6:0]       cnt_q, cnt_d;
    logic             shift_q, shift_d;
    logic [WIDTH-1:0] sr_in_q, sr_in_d;
    logic             primed_q, primed_d;
    logic             busy_q, busy_d;
    logic             accept;

    assign in_ready = (state_q != FLUSH) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        shift_d = 1'b0;
        sr_in_d = sr_in_q;
        busy_d  = 1'b0;
        if (state_q == FLUSH) begin
            // Counter was loaded with DEPTH on entry; the entry edge already issued the first zero pulse.
            cnt_d = cnt_q - 7'd1;
            if (cnt_d != 7'd0) begin
                shift_d = 1'b1;
                sr_in_d = '0;
                busy_d  = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else if (flush) begin
            state_d = FLUSH;
            fill_d  = 7'd0;
            cnt_d   = DEPTH_L;
            shift_d = 1'b1;
            sr_in_d = '0;
            busy_d  = 1'b1;
        end else if (accept) begin
            shift_d = 1'b1;
            sr_in_d = in_data;
            if (fill_q != DEPTH_L) fill_d = fill_q + 7'd1;
            state_d = (fill_d == DEPTH_L) ? RUN : FILL;
        end
        primed_d = (fill_d == DEPTH_L);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            fill_q   <= 7'd0;
            cnt_q    <= 7'd0;
            shift_q  <= 1'b0;
            sr_in_q  <= '0;
            primed_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            sr_in_q  <= sr_in_d;
            primed_q <= primed_d;
            busy_q   <= busy_d;
        end
    end

    assign shift      = shift_q;
    assign sr_in      = sr_in_q;
    assign fill_level = fill_q;
    assign primed     = primed_q;
    assign busy       = busy_q;

`ifdef SR_FEED_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= 16'd0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_shift_8x64_feeder.sv
// Directed bench for shift_8x64_feeder: scoreboard of expected sr_in bytes, checked on each shift pulse.
module tb_shift_8x64_feeder;
    localparam int W = 8;
    localparam int D = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic         in_ready, shift, primed, busy;
    logic [W-1:0] sr_in;
    logic [6:0]   fill_level;
`ifdef SR_FEED_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    shift_8x64_feeder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .shift(shift), .sr_in(sr_in),
        .fill_level(fill_level), .primed(primed), .busy(busy)
`ifdef SR_FEED_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] q[$];
    int m_fill = 0;
    int m_zero = 0;
    bit m_busy = 1'b0;
    int m_stall = 0;
    int n_shift = 0;
    int n_busy = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check in_ready before the edge, then outputs 1 time unit after it.
    task automatic cycle();
        bit exp_ready, acc, exp_shift;
        logic [W-1:0] e;
        #1;
        exp_ready = !flush && !m_busy;
        chk("in_ready", in_ready, exp_ready);
        acc = in_valid && exp_ready;
        if (in_valid && !exp_ready && m_stall < 65535) m_stall++;
        if (acc) begin
            q.push_back(in_data);
            if (m_fill < D) m_fill++;
        end
        if (flush && !m_busy) begin
            m_fill = 0;
            m_zero = D;
        end
        @(posedge clk);
        #1;
        exp_shift = acc;
        m_busy = 1'b0;
        if (m_zero > 0) begin
            exp_shift = 1'b1;
            m_busy = 1'b1;
            m_zero--;
            q.push_back('0);
        end
        chk("shift", shift, exp_shift);
        chk("busy", busy, m_busy);
        chk("fill_level", fill_level, m_fill);
        chk("primed", primed, (m_fill == D));
        if (shift) n_shift++;
        if (busy) n_busy++;
        if (exp_shift && q.size() > 0) begin
            e = q.pop_front();
            chk("sr_in", sr_in, e);
        end
`ifdef SR_FEED_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("rst_shift", shift, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_primed", primed, 0);
        chk("rst_sr_in", sr_in, 0);
`ifdef SR_FEED_STALL_CNT_EN
        chk("rst_stall", stall_cnt, 0);
`endif
        q.delete();
        m_fill = 0; m_zero = 0; m_busy = 1'b0; m_stall = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Fill from reset with 0x00..0x3F, then 10 more bytes in RUN
        do_reset();
        n_shift = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_data = W'(i);
            cycle();
        end
        chk("fill64_pulses", n_shift, 64);
        chk("fill64_level", fill_level, 64);
        chk("fill64_primed", primed, 1);
        n_shift = 0;
        in_data = 8'hFF;
        repeat (10) cycle();
        in_valid = 1'b0;
        chk("run_pulses", n_shift, 10);
        chk("run_level", fill_level, 64);

        // Flush from RUN with a second flush pulse mid-FLUSH
        n_shift = 0; n_busy = 0;
        flush = 1'b1; cycle(); flush = 1'b0;
        chk("flush_primed_fall", primed, 0);
        repeat (9) cycle();
        flush = 1'b1; cycle(); flush = 1'b0;
        repeat (60) cycle();
        chk("reflush_pulses", n_shift, 64);
        chk("reflush_busy", n_busy, 64);

        // in_valid toggling over 16 cycles
        n_shift = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = (i % 2 == 0);
            in_data = W'(8'h80 + i);
            cycle();
        end
        in_valid = 1'b0;
        chk("toggle_pulses", n_shift, 8);
        chk("toggle_level", fill_level, 8);
        chk("toggle_primed", primed, 0);

        // Fill to 20, flush with in_valid high
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = W'(8'h40 + i);
            cycle();
        end
        chk("pre_flush_level", fill_level, 20);
        n_shift = 0; n_busy = 0;
        flush = 1'b1;
        #1;
        chk("ready_low_on_flush", in_ready, 0);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        repeat (64) cycle();
        chk("flush20_pulses", n_shift, 64);
        chk("flush20_busy", n_busy, 64);
        chk("ready_after_flush", in_ready, 1);

        // Flush from IDLE, reset at the 30th zero pulse
        n_shift = 0;
        flush = 1'b1; cycle(); flush = 1'b0;
        repeat (29) cycle();
        chk("pulses_before_reset", n_shift, 30);
        #2;
        do_reset();
        in_valid = 1'b1; in_data = 8'hA5;
        cycle();
        in_valid = 1'b0;
        chk("post_reset_level", fill_level, 1);
        cycle();

        // Flush with in_valid held high through FLUSH
        do_reset();
        n_shift = 0;
        in_valid = 1'b1; in_data = 8'h3C;
        flush = 1'b1; cycle(); flush = 1'b0;
        repeat (64) cycle();
`ifdef SR_FEED_STALL_CNT_EN
        chk("stall_65", stall_cnt, 65);
`endif
        chk("stall_pulses", n_shift, 64);
        cycle();
        in_valid = 1'b0;
        chk("accept_after_flush", fill_level, 1);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/shift_8x64_feeder.md
SHIFT_8X64_FEEDER -- requirements
Module: shift_8x64_feeder

Interface
REQ-001 Parameter WIDTH, default 8, data byte width driven into the shift register.
REQ-002 Parameter DEPTH, default 64, number of stages in the driven shift register.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  WIDTH  upstream byte.
REQ-006 in_valid  input  1  upstream byte present.
REQ-007 in_ready  output  1  feeder accepts in_data this cycle.
REQ-008 flush  input  1  single-cycle request to clear the shift register with zeros.
REQ-009 shift  output  1  shift enable to the 8x64 shift register.
REQ-010 sr_in  output  WIDTH  data into the shift register.
REQ-011 fill_level  output  7  count of valid bytes in the shift register, 0..DEPTH.
REQ-012 primed  output  1  high when fill_level == DEPTH (all taps hold valid data).
REQ-013 busy  output  1  high while a flush is in progress.
REQ-014 stall_cnt  output  16  present only when SR_FEED_STALL_CNT_EN is defined.

Function
REQ-015 States: IDLE (fill_level 0), FILL (0 < fill_level < DEPTH), RUN (fill_level == DEPTH), FLUSH.
REQ-016 in_ready = 1 in IDLE/FILL/RUN when flush is low; 0 in FLUSH and in any cycle flush is high (combinational).
REQ-017 Accept = in_valid & in_ready; on the accept edge, shift and sr_in are registered: shift = 1 and sr_in = in_data for exactly the next cycle (latency 1).
REQ-018 With no accept, shift = 0 and sr_in holds its last value (except during FLUSH).
REQ-019 Back-to-back accepts produce one shift pulse per cycle, no bubbles.
REQ-020 fill_level increments by 1 per accept, saturating at DEPTH; RUN accepts continue with fill_level held at DEPTH.
REQ-021 Transitions: IDLE->FILL on first accept; FILL->RUN on the accept that makes fill_level DEPTH.
REQ-022 flush high in IDLE/FILL/RUN: enter FLUSH, clear fill_level to 0, load the internal flush counter with DEPTH; no byte is accepted in that cycle.
REQ-023 In FLUSH: emit exactly DEPTH consecutive shift pulses with sr_in = 0; then return to IDLE; busy = 1 from the cycle after flush is sampled through the last zero pulse.
REQ-024 flush asserted while in FLUSH is ignored; no restart, no extension.
REQ-025 flush in IDLE with fill_level 0 still performs the full DEPTH-pulse flush, clearing any stale register contents.
REQ-026 primed is registered and equals (fill_level == DEPTH); it falls in the same cycle FLUSH is entered.

Reset
REQ-027 rst_n low asynchronously forces state IDLE, shift 0, sr_in 0, fill_level 0, primed 0, busy 0, flush counter 0, stall_cnt 0.
REQ-028 Reset mid-FLUSH or mid-FILL aborts the operation; the first edge after release behaves as from IDLE with no pending pulses.

Configuration
REQ-029 Macro SR_FEED_STALL_CNT_EN defined: stall_cnt increments on every cycle with in_valid = 1 and in_ready = 0, saturating at 16'hFFFF and cleared only by reset.
REQ-030 SR_FEED_STALL_CNT_EN undefined: stall_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-031 Reset release, in_valid held 1 with bytes 0x00..0x3F over 64 cycles -> 64 shift pulses each one cycle after accept with matching sr_in; fill_level 64; primed rises after the 64th accept.
REQ-032 In RUN, push 0xFF for 10 more cycles -> 10 shift pulses, fill_level stays 64, primed stays 1.
REQ-033 fill_level 20, pulse flush with in_valid high -> in_ready 0 that cycle, fill_level 0, busy high for exactly 64 cycles, 64 shift pulses with sr_in 0x00, then IDLE and in_ready 1.
REQ-034 Second flush pulse mid-FLUSH -> total zero pulses still exactly 64; with SR_FEED_STALL_CNT_EN, in_valid held 1 throughout FLUSH -> stall_cnt equals 65 (flush cycle plus 64 FLUSH cycles).
REQ-035 rst_n low for 1 cycle at flush pulse 30 -> shift, busy, fill_level 0 immediately; next accept gives fill_level 1, state FILL.
REQ-036 in_valid toggling 1/0 for 16 cycles -> exactly 8 shift pulses, fill_level 8, primed 0.
